// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-access stage: memory aluop codes,
// common data/control constants, FSM state encoding and op classifiers.
package mem_access_ctrl_pkg;

    // Memory-op aluop codes
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [31:0] ZeroWord     = '0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Big-endian byte-lane alignment: lane enables, replicated store data,
// extended load data and the misalignment flag for one memory op.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_ext_o,
    output logic        misaligned_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [3:0]  sel_b;
    logic [3:0]  sel_h;

    // Lane selection shared by loads and stores; byte 0 of the word is rdata[31:24]
    always_comb begin
        rbyte = rdata_i[31:24];
        sel_b = 4'b1000;
        case (addr_lo_i)
            2'b00: begin rbyte = rdata_i[31:24]; sel_b = 4'b1000; end
            2'b01: begin rbyte = rdata_i[23:16]; sel_b = 4'b0100; end
            2'b10: begin rbyte = rdata_i[15:8];  sel_b = 4'b0010; end
            2'b11: begin rbyte = rdata_i[7:0];   sel_b = 4'b0001; end
            default: begin rbyte = rdata_i[31:24]; sel_b = 4'b1000; end
        endcase
        rhalf = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        sel_h = addr_lo_i[1] ? 4'b0011 : 4'b1100;
    end

    // Per-op decode of enables, store data, load extension and alignment
    always_comb begin
        sel_o        = 4'b0000;
        wdata_o      = ZeroWord;
        rdata_ext_o  = ZeroWord;
        misaligned_o = 1'b0;
        case (aluop_i)
            EXE_LB_OP: begin
                sel_o       = sel_b;
                rdata_ext_o = {{24{rbyte[7]}}, rbyte};
            end
            EXE_LBU_OP: begin
                sel_o       = sel_b;
                rdata_ext_o = {24'h0, rbyte};
            end
            EXE_LH_OP: begin
                sel_o        = sel_h;
                rdata_ext_o  = {{16{rhalf[15]}}, rhalf};
                misaligned_o = addr_lo_i[0];
            end
            EXE_LHU_OP: begin
                sel_o        = sel_h;
                rdata_ext_o  = {16'h0, rhalf};
                misaligned_o = addr_lo_i[0];
            end
            EXE_LW_OP: begin
                sel_o        = 4'b1111;
                rdata_ext_o  = rdata_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            EXE_SB_OP: begin
                sel_o   = sel_b;
                wdata_o = {4{reg2_i[7:0]}};
            end
            EXE_SH_OP: begin
                sel_o        = sel_h;
                wdata_o      = {2{reg2_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            EXE_SW_OP: begin
                sel_o        = 4'b1111;
                wdata_o      = reg2_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access stage: single-outstanding req/ack bus master for loads and
// stores, stall generation, address-error and ack-timeout detection, and
// zero-latency pass-through of non-memory ops to MEM/WB.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_err_o
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic       TMO_EN   = (ACK_TIMEOUT != 0);

    mem_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    logic        op_load;
    logic        op_store;
    logic        op_mem;
    logic        misaligned;
    logic        start;
    logic        tmo_hit;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    mem_lane_align u_lane_align (
        .aluop_i      (aluop_i),
        .addr_lo_i    (mem_addr_i[1:0]),
        .reg2_i       (reg2_i),
        .rdata_i      (bus_rdata_i),
        .sel_o        (lane_sel),
        .wdata_o      (lane_wdata),
        .rdata_ext_o  (lane_rdata),
        .misaligned_o (misaligned)
    );

    // Op classification and access-start / timeout conditions
    always_comb begin
        op_load  = is_load_op(aluop_i);
        op_store = is_store_op(aluop_i);
        op_mem   = op_load | op_store;
        start    = op_mem && !misaligned && !flush;
        tmo_hit  = TMO_EN && (tmo_cnt_q == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; ack beats timeout, flush during BUSY waits out the bus in ABORT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus_ack_i)  state_d = flush ? ST_IDLE : ST_DONE;
                else if (flush) state_d = ST_ABORT;
                else if (tmo_hit) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: if (bus_ack_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus, load-data and timeout-counter next values
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = 1'b0;
        load_data_d = load_data_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = op_store;
                    bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_d   = lane_sel;
                    bus_wdata_d = lane_wdata;
                    tmo_cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (bus_ack_i) begin
                    bus_req_d   = 1'b0;
                    load_data_d = lane_rdata;
                end else if (!flush) begin
                    if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_hit) begin
                        bus_req_d = 1'b0;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_ABORT: if (bus_ack_i) bus_req_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            load_data_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            load_data_q <= load_data_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // MEM/WB outputs and stall request
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stallreq_o = NoStop;
        if (op_mem && misaligned) wreg_o = WriteDisable;
        case (state_q)
            ST_IDLE, ST_ABORT: begin
                if (start) begin
                    stallreq_o = Stop;
                    wreg_o     = WriteDisable;
                end
            end
            ST_BUSY: begin
                stallreq_o = Stop;
                wreg_o     = WriteDisable;
            end
            ST_DONE: begin
                if (op_store) wreg_o = WriteDisable;
                else          wdata_o = load_data_q;
                if (bus_err_q) wreg_o = WriteDisable;
            end
            default: ;
        endcase
    end

    // Combinational address errors and registered bus outputs
    always_comb begin
        adel_o      = op_load && misaligned;
        ades_o      = op_store && misaligned;
        bus_req_o   = bus_req_q;
        bus_we_o    = bus_we_q;
        bus_addr_o  = bus_addr_q;
        bus_sel_o   = bus_sel_q;
        bus_wdata_o = bus_wdata_q;
        bus_err_o   = bus_err_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (ACK_TIMEOUT = 4).
module tb_mem_access_ctrl;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, bus_ack_i;
    logic        bus_req_o, bus_we_o, wreg_o, stallreq_o, adel_o, ades_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  wd_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .adel_o(adel_o), .ades_o(ades_o), .bus_err_o(bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        wd_i       = wd;
        wreg_i     = wr;
        wdata_i    = wdat;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        setop(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick(); tick(); #1;
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        rst = 1'b0;

        // SW 0x100, two wait cycles
        tick(); setop(OP_SW, 32'h100, 32'hDEADBEEF, 5'd3, 1'b1, 32'h100); #1;
        chk("sw_idle_stall", 32'(stallreq_o), 32'd1);
        chk("sw_idle_req", 32'(bus_req_o), 32'd0);
        tick(); #1;
        chk("sw_req", 32'(bus_req_o), 32'd1);
        chk("sw_sel", 32'(bus_sel_o), 32'hF);
        chk("sw_addr", bus_addr_o, 32'h100);
        chk("sw_we", 32'(bus_we_o), 32'd1);
        chk("sw_wdata", bus_wdata_o, 32'hDEADBEEF);
        chk("sw_busy1_stall", 32'(stallreq_o), 32'd1);
        tick(); #1;
        chk("sw_busy2_stall", 32'(stallreq_o), 32'd1);
        tick(); bus_ack_i = 1'b1; #1;
        chk("sw_busy3_stall", 32'(stallreq_o), 32'd1);
        chk("sw_busy3_req", 32'(bus_req_o), 32'd1);
        tick(); bus_ack_i = 1'b0; #1;
        chk("sw_done_stall", 32'(stallreq_o), 32'd0);
        chk("sw_done_req", 32'(bus_req_o), 32'd0);
        chk("sw_done_wreg", 32'(wreg_o), 32'd0);

        // LB 0x203 zero-wait
        tick(); setop(OP_LB, 32'h203, 32'h0, 5'd5, 1'b1, 32'h12345678); #1;
        chk("lb_idle_stall", 32'(stallreq_o), 32'd1);
        tick(); bus_ack_i = 1'b1; bus_rdata_i = 32'h112233F0; #1;
        chk("lb_sel", 32'(bus_sel_o), 32'h1);
        chk("lb_addr", bus_addr_o, 32'h200);
        chk("lb_we", 32'(bus_we_o), 32'd0);
        tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; #1;
        chk("lb_wdata", wdata_o, 32'hFFFFFFF0);
        chk("lb_wreg", 32'(wreg_o), 32'd1);
        chk("lb_wd", 32'(wd_o), 32'd5);
        chk("lb_done_stall", 32'(stallreq_o), 32'd0);

        // LBU same address
        tick(); setop(OP_LBU, 32'h203, 32'h0, 5'd5, 1'b1, 32'h12345678);
        tick(); bus_ack_i = 1'b1; bus_rdata_i = 32'h112233F0;
        tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; #1;
        chk("lbu_wdata", wdata_o, 32'h000000F0);

        // Non-memory pass-through
        tick(); setop(OP_NOP, 32'h203, 32'h0, 5'd6, 1'b1, 32'h55AA55AA); #1;
        chk("pt_wdata", wdata_o, 32'h55AA55AA);
        chk("pt_wreg", 32'(wreg_o), 32'd1);
        chk("pt_wd", 32'(wd_o), 32'd6);
        chk("pt_stall", 32'(stallreq_o), 32'd0);

        // Misaligned LH and SW
        tick(); setop(OP_LH, 32'h301, 32'h0, 5'd8, 1'b1, 32'h77); #1;
        chk("lh_adel", 32'(adel_o), 32'd1);
        chk("lh_ades", 32'(ades_o), 32'd0);
        chk("lh_stall", 32'(stallreq_o), 32'd0);
        chk("lh_wreg", 32'(wreg_o), 32'd0);
        tick(); #1;
        chk("lh_noreq", 32'(bus_req_o), 32'd0);
        setop(OP_SW, 32'h102, 32'h0, 5'd0, 1'b0, 32'h0); #1;
        chk("sw_mis_ades", 32'(ades_o), 32'd1);
        chk("sw_mis_adel", 32'(adel_o), 32'd0);
        tick(); #1;
        chk("sw_mis_noreq", 32'(bus_req_o), 32'd0);

        // SB lane at addr 01, SH lane at addr 10
        setop(OP_SB, 32'h701, 32'h123456AB, 5'd0, 1'b0, 32'h0);
        tick(); #1;
        chk("sb_sel", 32'(bus_sel_o), 32'h4);
        chk("sb_wdata", bus_wdata_o, 32'hABABABAB);
        bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0;
        tick(); setop(OP_SH, 32'h702, 32'h0000BEEF, 5'd0, 1'b0, 32'h0);
        tick(); #1;
        chk("sh_sel", 32'(bus_sel_o), 32'h3);
        chk("sh_wdata", bus_wdata_o, 32'hBEEFBEEF);
        bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0;

        // Flush in BUSY, ack three cycles later, pending LW waits for IDLE
        tick(); setop(OP_LW, 32'h400, 32'h0, 5'd7, 1'b1, 32'h0); #1;
        chk("fl_idle_stall", 32'(stallreq_o), 32'd1);
        tick(); flush = 1'b1; #1;
        chk("fl_busy_req", 32'(bus_req_o), 32'd1);
        tick(); flush = 1'b0; setop(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000AAAA); #1;
        chk("fl_abort_req", 32'(bus_req_o), 32'd1);
        chk("fl_abort_stall", 32'(stallreq_o), 32'd0);
        chk("fl_abort_wreg", 32'(wreg_o), 32'd0);
        tick(); setop(OP_LW, 32'h500, 32'h0, 5'd9, 1'b1, 32'h0); #1;
        chk("fl_abort_newop_stall", 32'(stallreq_o), 32'd1);
        chk("fl_abort_addr_held", bus_addr_o, 32'h400);
        tick(); bus_ack_i = 1'b1; #1;
        chk("fl_abort_req_till_ack", 32'(bus_req_o), 32'd1);
        tick(); bus_ack_i = 1'b0; #1;
        chk("fl_idle_req", 32'(bus_req_o), 32'd0);
        chk("fl_idle_newop_stall", 32'(stallreq_o), 32'd1);
        chk("fl_idle_wreg", 32'(wreg_o), 32'd0);
        tick(); #1;
        chk("fl_new_req", 32'(bus_req_o), 32'd1);
        chk("fl_new_addr", bus_addr_o, 32'h500);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; #1;
        chk("fl_new_wdata", wdata_o, 32'hCAFEF00D);
        chk("fl_new_wreg", 32'(wreg_o), 32'd1);
        chk("fl_new_wd", 32'(wd_o), 32'd9);

        // Timeout with ACK_TIMEOUT = 4
        tick(); setop(OP_LW, 32'h600, 32'h0, 5'd10, 1'b1, 32'h0);
        tick(); tick(); tick(); tick(); #1;
        chk("to_busy4_req", 32'(bus_req_o), 32'd1);
        chk("to_busy4_err", 32'(bus_err_o), 32'd0);
        tick(); #1;
        chk("to_done_err", 32'(bus_err_o), 32'd1);
        chk("to_done_req", 32'(bus_req_o), 32'd0);
        chk("to_done_wreg", 32'(wreg_o), 32'd0);
        chk("to_done_stall", 32'(stallreq_o), 32'd0);
        tick(); setop(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0); #1;
        chk("to_err_pulse", 32'(bus_err_o), 32'd0);
        chk("to_idle_req", 32'(bus_req_o), 32'd0);

        // Back-to-back SW 0x10 then LW 0x14, reset mid-BUSY
        tick(); setop(OP_SW, 32'h10, 32'h01020304, 5'd0, 1'b0, 32'h0);
        tick(); bus_ack_i = 1'b1; #1;
        chk("bb_sw_addr", bus_addr_o, 32'h10);
        tick(); bus_ack_i = 1'b0; #1;
        chk("bb_sw_done_stall", 32'(stallreq_o), 32'd0);
        tick(); setop(OP_LW, 32'h14, 32'h0, 5'd2, 1'b1, 32'h0); #1;
        chk("bb_lw_idle_stall", 32'(stallreq_o), 32'd1);
        chk("bb_lw_idle_req", 32'(bus_req_o), 32'd0);
        tick(); #1;
        chk("bb_lw_req", 32'(bus_req_o), 32'd1);
        chk("bb_lw_addr", bus_addr_o, 32'h14);
        chk("bb_lw_we", 32'(bus_we_o), 32'd0);
        rst = 1'b1;
        setop(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick(); #1;
        chk("mrst_req", 32'(bus_req_o), 32'd0);
        chk("mrst_we", 32'(bus_we_o), 32'd0);
        chk("mrst_sel", 32'(bus_sel_o), 32'd0);
        chk("mrst_addr", bus_addr_o, 32'h0);
        chk("mrst_wdata", bus_wdata_o, 32'h0);
        chk("mrst_err", 32'(bus_err_o), 32'd0);
        chk("mrst_stall", 32'(stallreq_o), 32'd0);
        chk("mrst_wreg", 32'(wreg_o), 32'd0);
        chk("mrst_wdata_o", wdata_o, 32'h0);
        rst = 1'b0;
        tick(); #1;
        chk("post_rst_req", 32'(bus_req_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
